uart_rx_io: RTL and testbench
=============================

// Module: uart_rx_io
// PURPOSE
//  Receive half of the host UART: deserialises 8N1 frames from the uart_rx pin into
//  a small FIFO and exposes data/status to the Z80 through IO reads.
//  Sits beside uart_io (transmit) on the clk_uart domain and decodes A[15:8].
//  Z80 bus strobes arrive from the CPU clock domain and are synchronised internally.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency
//  BAUD        115200      line rate; 16x oversample tick every CLK_HZ/(BAUD*16) clks (27)
//  FIFO_DEPTH  4           receive FIFO entries, power of two, >=2
// PORTS
//  clk       in     1  UART clock (50 MHz)
//  reset     in     1  asynchronous, active-high
//  Address   in     8  IO address high byte (CPU A[15:8])
//  Data      out    8  read data; driven while selected read active, else 8'hzz
//  IORQ      in     1  active-high IO request
//  RD        in     1  active-high read strobe
//  WR        in     1  active-high write strobe (writes ignored)
//  uart_rx   in     1  serial input, idle high
//  rx_avail  out    1  FIFO non-empty; usable as interrupt source (inverted to nINT)
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, rx_avail=0, overrun=0, framing=0, Data=z, tick ctr 0.
//  Input sync: uart_rx through 2 flops (reset to 1); IORQ&RD&sel through 2 flops.
//  IO map: 01xx read = pop FIFO head; 03xx read = status {5'b0,framing,overrun,rx_avail}.
//   Data is combinational from unsynchronised IORQ&RD&Address: head byte, or 8'h00 if empty.
//  Pop on falling edge of synced data-read strobe, one pop per bus cycle; empty -> no pop.
//  Status read: overrun/framing cleared on falling edge of synced status-read strobe.
//  Baud tick: counter DIV-1..0, tick pulses 1 clk; runs free in all states.
//  FSM (bit ctr b[3:0] counts ticks within bit):
//   IDLE: rx=0 -> START, b=0.
//   START: on tick b++; at b==7 rx=1 -> IDLE (glitch); rx=0 -> DATA, b=0, n=0.
//   DATA: at b==15 sample rx into shift[7] (LSB first, shift right), n++; n==8 -> STOP.
//   STOP: at b==15 sample; rx=1 -> push byte, IDLE; rx=0 -> framing=1, drop byte, BREAK.
//   BREAK: wait for synced rx=1 -> IDLE (no start detect on held-low line).
//  Push when full with no same-cycle pop: overrun=1, byte dropped, FIFO unchanged.
//  Same-cycle push+pop: both occur; full stays full, no overrun.
//  Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  Latency: byte visible (rx_avail=1) 1 clk after stop-bit sample (~9.5 bits after start edge).
//  reset asserted mid-frame: immediate abort to reset state, partial byte discarded.
// STRUCTURE
//  uart_defs.vh (shared with uart_io): IO port high-bytes (UART_TX=8'h00, UART_TXST=8'h02,
//   UART_RX=8'h01, UART_RXST=8'h03), FSM state encodings, status bit indices.
//  Sub-module uart_rx_fifo: sync FIFO, push/pop/full/empty/head, parameter DEPTH.
//  Top: synchronisers, tick gen, FSM, bus decode + edge detect.
// TESTING
//  Send 8'hA5 at BAUD, IO read 0x0100 -> Data=A5, rx_avail 1->0 after read ends.
//  Send 5 bytes 01..05, no reads -> status=8'h03; reads yield 01..04; status read clears -> 8'h00.
//  Stop bit driven 0 on 8'h3C -> FIFO empty, status=8'h04; line held low 2 frames -> no new bytes.
//  800 ns low glitch on idle line -> FSM back to IDLE, nothing pushed, no flags.
//  reset pulse mid-byte (after 4 data bits), then clean 8'h7E -> only 7E received.
//  Data read on empty FIFO -> Data=00, no pointer change; WR to 0x01xx -> no effect.

Source files
------------

// File: rtl/uart_rx_io_pkg.sv
// Shared UART definitions: IO port high bytes, receiver FSM encoding,
// status bit positions and a status-byte packing helper.
package uart_rx_io_pkg;

   // IO port high bytes (CPU A[15:8])
   localparam logic [7:0] UART_TX   = 8'h00;
   localparam logic [7:0] UART_RX   = 8'h01;
   localparam logic [7:0] UART_TXST = 8'h02;
   localparam logic [7:0] UART_RXST = 8'h03;

   // Receive status register bit positions
   localparam int ST_AVAIL   = 0;
   localparam int ST_OVERRUN = 1;
   localparam int ST_FRAMING = 2;

   // Receiver FSM states
   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rxState_e;

   // Pack the receive status byte {5'b0, framing, overrun, avail}
   function automatic logic [7:0] makeStatus(input logic avail,
                                             input logic overrun,
                                             input logic framing);
      logic [7:0] st;
      st             = 8'h00;
      st[ST_AVAIL]   = avail;
      st[ST_OVERRUN] = overrun;
      st[ST_FRAMING] = framing;
      return st;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO. Push is refused when full unless a pop
// happens in the same cycle; pop is ignored when empty.
module uart_rx_fifo
   import uart_rx_io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wrPtr_r;
   logic [AW-1:0] rdPtr_r;
   logic [CW-1:0] count_r;
   logic          doPush_s;
   logic          doPop_s;

   assign full     = (count_r == CW'(DEPTH));
   assign empty    = (count_r == {CW{1'b0}});
   assign head     = mem_r[rdPtr_r];
   assign doPop_s  = pop & ~empty;
   assign doPush_s = push & (~full | doPop_s);

   // Storage, pointers and occupancy count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wrPtr_r <= {AW{1'b0}};
         rdPtr_r <= {AW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         if (doPush_s) begin
            mem_r[wrPtr_r] <= din;
            wrPtr_r        <= wrPtr_r + AW'(1);
         end
         if (doPop_s) begin
            rdPtr_r <= rdPtr_r + AW'(1);
         end
         case ({doPush_s, doPop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_io.sv
// UART receiver with Z80 IO read interface: 8N1 deserialiser with 16x
// oversampling, receive FIFO, and overrun/framing status flags.
module uart_rx_io
   import uart_rx_io_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Address,
   output logic [7:0] Data,
   input  logic       IORQ,
   input  logic       RD,
   input  logic       WR,
   input  logic       uart_rx,
   output logic       rx_avail
);

   localparam int DIV  = CLK_HZ / (BAUD * 16);
   localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;

   rxState_e      state_r, stateNext_s;
   logic [3:0]    bitCnt_r, bitNext_s;
   logic [2:0]    nCnt_r, nNext_s;
   logic [7:0]    shift_r, shiftNext_s;
   logic [DIVW-1:0] tickCnt_r;
   logic          tick_s;
   logic [1:0]    rxSync_r;
   logic          rxIn_s;
   logic [2:0]    dataRdSync_r;
   logic [2:0]    statRdSync_r;
   logic          dataFall_s;
   logic          statFall_s;
   logic          push_s;
   logic          frameErr_s;
   logic          overrun_r;
   logic          framing_r;
   logic          fifoFull_s;
   logic          fifoEmpty_s;
   logic [7:0]    fifoHead_s;
   logic          popReq_s;
   logic          readCycle_s;
   logic          dataSel_s;
   logic          statSel_s;

   // A cycle with both strobes asserted is treated as malformed, not a read
   assign readCycle_s = IORQ & RD & ~WR;
   assign dataSel_s   = readCycle_s & (Address == UART_RX);
   assign statSel_s   = readCycle_s & (Address == UART_RXST);
   assign rxIn_s      = rxSync_r[1];
   assign dataFall_s  = dataRdSync_r[2] & ~dataRdSync_r[1];
   assign statFall_s  = statRdSync_r[2] & ~statRdSync_r[1];
   assign popReq_s    = dataFall_s & ~fifoEmpty_s;
   assign rx_avail    = ~fifoEmpty_s;
   assign tick_s      = (tickCnt_r == {DIVW{1'b0}});

   // Read data driven straight from the unsynchronised bus decode
   assign Data = dataSel_s ? (fifoEmpty_s ? 8'h00 : fifoHead_s) :
                 statSel_s ? makeStatus(~fifoEmpty_s, overrun_r, framing_r) :
                 8'hzz;

   // Synchronise serial line and bus read strobes into the UART clock domain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxSync_r     <= 2'b11;
         dataRdSync_r <= 3'b000;
         statRdSync_r <= 3'b000;
      end else begin
         rxSync_r     <= {rxSync_r[0], uart_rx};
         dataRdSync_r <= {dataRdSync_r[1:0], dataSel_s};
         statRdSync_r <= {statRdSync_r[1:0], statSel_s};
      end
   end

   // Free-running 16x oversample tick divider
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tickCnt_r <= {DIVW{1'b0}};
      end else if (tick_s) begin
         tickCnt_r <= DIVW'(DIV - 1);
      end else begin
         tickCnt_r <= tickCnt_r - DIVW'(1);
      end
   end

   // Receiver state and bit/byte counters register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= RX_IDLE;
         bitCnt_r <= 4'd0;
         nCnt_r   <= 3'd0;
         shift_r  <= 8'h00;
      end else begin
         state_r  <= stateNext_s;
         bitCnt_r <= bitNext_s;
         nCnt_r   <= nNext_s;
         shift_r  <= shiftNext_s;
      end
   end

   // Receiver next-state: start validation at mid start bit, mid-bit sampling
   always_comb begin
      stateNext_s = state_r;
      bitNext_s   = bitCnt_r;
      nNext_s     = nCnt_r;
      shiftNext_s = shift_r;
      push_s      = 1'b0;
      frameErr_s  = 1'b0;
      case (state_r)
         RX_IDLE: begin
            if (!rxIn_s) begin
               stateNext_s = RX_START;
               bitNext_s   = 4'd0;
            end else begin
               stateNext_s = RX_IDLE;
            end
         end
         RX_START: begin
            if (tick_s) begin
               if (bitCnt_r == 4'd7) begin
                  if (rxIn_s) begin
                     stateNext_s = RX_IDLE;
                  end else begin
                     stateNext_s = RX_DATA;
                     bitNext_s   = 4'd0;
                     nNext_s     = 3'd0;
                  end
               end else begin
                  bitNext_s = bitCnt_r + 4'd1;
               end
            end else begin
               bitNext_s = bitCnt_r;
            end
         end
         RX_DATA: begin
            if (tick_s) begin
               if (bitCnt_r == 4'd15) begin
                  shiftNext_s = {rxIn_s, shift_r[7:1]};
                  bitNext_s   = 4'd0;
                  nNext_s     = nCnt_r + 3'd1;
                  if (nCnt_r == 3'd7) begin
                     stateNext_s = RX_STOP;
                  end else begin
                     stateNext_s = RX_DATA;
                  end
               end else begin
                  bitNext_s = bitCnt_r + 4'd1;
               end
            end else begin
               bitNext_s = bitCnt_r;
            end
         end
         RX_STOP: begin
            if (tick_s) begin
               if (bitCnt_r == 4'd15) begin
                  if (rxIn_s) begin
                     push_s      = 1'b1;
                     stateNext_s = RX_IDLE;
                  end else begin
                     frameErr_s  = 1'b1;
                     stateNext_s = RX_BREAK;
                  end
               end else begin
                  bitNext_s = bitCnt_r + 4'd1;
               end
            end else begin
               bitNext_s = bitCnt_r;
            end
         end
         RX_BREAK: begin
            if (rxIn_s) begin
               stateNext_s = RX_IDLE;
            end else begin
               stateNext_s = RX_BREAK;
            end
         end
         default: begin
            stateNext_s = RX_IDLE;
         end
      endcase
   end

   // Sticky error flags; a new error in the clearing cycle takes precedence
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_r <= 1'b0;
         framing_r <= 1'b0;
      end else begin
         if (push_s && fifoFull_s && !popReq_s) begin
            overrun_r <= 1'b1;
         end else if (statFall_s) begin
            overrun_r <= 1'b0;
         end else begin
            overrun_r <= overrun_r;
         end
         if (frameErr_s) begin
            framing_r <= 1'b1;
         end else if (statFall_s) begin
            framing_r <= 1'b0;
         end else begin
            framing_r <= framing_r;
         end
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (popReq_s),
      .din   (shift_r),
      .head  (fifoHead_s),
      .full  (fifoFull_s),
      .empty (fifoEmpty_s)
   );

endmodule

// File: tb/tb_uart_rx_io.sv
// Bench for uart_rx_io: serial frames in, IO reads out, compared against a
// frame-level model (byte queue plus sticky error flags).
module tb_uart_rx_io;

   localparam int CLK_HZ = 50_000_000;
   localparam int BAUD   = 347_222;          // oversample divider of 9 keeps the run short
   localparam int DIV    = CLK_HZ / (BAUD * 16);
   localparam int BITCLK = 16 * DIV;
   localparam int DEPTH  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] address = 8'h00;
   wire  [7:0] dataBus;
   logic       iorq = 1'b0;
   logic       rd = 1'b0;
   logic       wr = 1'b0;
   logic       rxLine = 1'b1;
   logic       rxAvail;

   int vecCnt = 0;
   int errCnt = 0;

   logic [7:0] modelQ[$];
   logic       mOverrun = 1'b0;
   logic       mFraming = 1'b0;

   uart_rx_io #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .Address  (address),
      .Data     (dataBus),
      .IORQ     (iorq),
      .RD       (rd),
      .WR       (wr),
      .uart_rx  (rxLine),
      .rx_avail (rxAvail)
   );

   always #10 clk = ~clk;

   task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vecCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one 8N1 frame; a low stop bit is followed by one idle bit
   task automatic sendFrame(input logic [7:0] b, input logic stopBit);
      rxLine = 1'b0;
      waitClk(BITCLK);
      for (int i = 0; i < 8; i++) begin
         rxLine = b[i];
         waitClk(BITCLK);
      end
      rxLine = stopBit;
      waitClk(BITCLK);
      rxLine = 1'b1;
      if (!stopBit) waitClk(BITCLK);
   endtask

   // Frame-level model update
   task automatic modelRx(input logic [7:0] b, input logic stopOk);
      if (!stopOk) mFraming = 1'b1;
      else if (modelQ.size() < DEPTH) modelQ.push_back(b);
      else mOverrun = 1'b1;
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopOk);
      sendFrame(b, stopOk);
      modelRx(b, stopOk);
   endtask

   task automatic ioRead(input logic [7:0] addr, output logic [7:0] val);
      address = addr;
      iorq = 1'b1;
      rd = 1'b1;
      waitClk(4);
      val = dataBus;
      iorq = 1'b0;
      rd = 1'b0;
      waitClk(6);
   endtask

   task automatic readData(input string tag);
      logic [7:0] v, exp;
      exp = (modelQ.size() != 0) ? modelQ[0] : 8'h00;
      ioRead(8'h01, v);
      checkVal(tag, v, exp);
      if (modelQ.size() != 0) void'(modelQ.pop_front());
   endtask

   task automatic readStatus(input string tag);
      logic [7:0] v, exp;
      exp = {5'b00000, mFraming, mOverrun, (modelQ.size() != 0)};
      ioRead(8'h03, v);
      checkVal(tag, v, exp);
      mFraming = 1'b0;
      mOverrun = 1'b0;
   endtask

   task automatic checkAvail(input string tag);
      checkVal(tag, {7'b0000000, rxAvail}, {7'b0000000, (modelQ.size() != 0)});
   endtask

   initial begin
      logic [7:0] b;
      int n;
      logic ok;

      waitClk(5);
      checkAvail("reset_avail");
      reset = 1'b0;
      waitClk(5);
      checkAvail("post_reset_avail");
      readStatus("reset_status");
      readData("reset_data_empty");

      // Single byte A5
      sendByte(8'hA5, 1'b1);
      checkAvail("a5_avail_before_read");
      readData("a5_data");
      checkAvail("a5_avail_after_read");

      // Five bytes, no reads: fifth overruns
      for (int i = 1; i <= 5; i++) sendByte(8'(i), 1'b1);
      readStatus("ovr_status");
      for (int i = 0; i < 4; i++) readData("ovr_data");
      checkAvail("ovr_avail_drained");
      readStatus("ovr_status_cleared");

      // Framing error, then line held low for two frame times
      sendFrame(8'h3C, 1'b0);
      mFraming = 1'b1;
      rxLine = 1'b0;
      waitClk(20 * BITCLK);
      rxLine = 1'b1;
      waitClk(2 * BITCLK);
      checkAvail("break_avail");
      readStatus("framing_status");
      readStatus("framing_cleared");

      // 800 ns glitch on idle line
      rxLine = 1'b0;
      waitClk(40);
      rxLine = 1'b1;
      waitClk(2 * BITCLK);
      checkAvail("glitch_avail");
      readStatus("glitch_status");

      // Reset in the middle of a byte, then a clean 7E
      b = 8'hC3;
      rxLine = 1'b0;
      waitClk(BITCLK);
      for (int i = 0; i < 4; i++) begin
         rxLine = b[i];
         waitClk(BITCLK);
      end
      reset = 1'b1;
      rxLine = 1'b1;
      waitClk(3);
      reset = 1'b0;
      modelQ.delete();
      mOverrun = 1'b0;
      mFraming = 1'b0;
      waitClk(12 * BITCLK);
      checkAvail("midreset_avail");
      readStatus("midreset_status");
      sendByte(8'h7E, 1'b1);
      readData("midreset_7e");
      readData("midreset_empty");

      // Empty read does not move pointers; writes are ignored
      readData("empty_read");
      sendByte(8'h5A, 1'b1);
      address = 8'h01;
      iorq = 1'b1;
      wr = 1'b1;
      waitClk(4);
      iorq = 1'b0;
      wr = 1'b0;
      waitClk(6);
      checkAvail("wr_ignored_avail");
      readData("wr_ignored_data");
      checkAvail("wr_ignored_drained");

      // Randomised bursts with occasional framing errors
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            sendByte(b, ok);
         end
         checkAvail("rnd_avail");
         readStatus("rnd_status");
         while (modelQ.size() != 0) readData("rnd_data");
         readData("rnd_data_empty");
         readStatus("rnd_status_clear");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
      $finish;
   end

endmodule
